// File: rtl/axil_mem_uart_slave.sv
// AXI4-Lite slave: MODE 0 = byte-strobed SRAM, MODE 1 = transmit-only UART console; one transaction in flight.
// Response valid LATENCY cycles after acceptance (writes add one capture cycle); rvalid/bvalid hold until rready/bready.
module axil_mem_uart_slave #(
  parameter int          MODE      = 0,
  parameter logic [31:0] BASE      = 32'h8000_0000,
  parameter int          SIZE_LOG2 = 14,
  parameter int          LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic        rresp,
  output logic        rvalid,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [31:0] wstrb,
  input  logic        wvalid,
  output logic        wready,
  input  logic        bready,
  output logic        bresp,
  output logic        bvalid,
  output logic        tx_valid,
  output logic [7:0]  tx_data
);

  localparam int DEPTH = 1 << (SIZE_LOG2 - 2);
  localparam int AW    = SIZE_LOG2 - 2;
  localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] RD_WAIT    = 3'd1;
  localparam logic [2:0] RD_RESP    = 3'd2;
  localparam logic [2:0] WR_COLLECT = 3'd3;
  localparam logic [2:0] WR_WAIT    = 3'd4;
  localparam logic [2:0] WR_RESP    = 3'd5;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [31:0]   rd_addr;
  logic [31:0]   wr_addr;
  logic [31:0]   wr_data;
  logic [3:0]    wr_strb;
  logic          aw_got;
  logic          w_got;
  logic          wr_err;
  logic          wr_thr;

  logic [31:0]   rd_off;
  logic [31:0]   wr_off;
  logic          rd_ok;
  logic          wr_ok;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  logic [31:0]   rd_word;
  logic          ar_hs;
  logic          aw_hs;
  logic          w_hs;
  logic          wr_go;
  logic          mem_we;

  // Unsigned offset: addresses below BASE wrap to huge values and fall out of range.
  assign rd_off = rd_addr - BASE;
  assign wr_off = wr_addr - BASE;
  assign rd_ok  = (rd_off[31:SIZE_LOG2] == '0);
  assign wr_ok  = (wr_off[31:SIZE_LOG2] == '0);
  assign rd_idx = rd_off[SIZE_LOG2-1:2];
  assign wr_idx = wr_off[SIZE_LOG2-1:2];

  assign arready = (state == IDLE);
  assign awready = ((state == IDLE) && !arvalid) || ((state == WR_COLLECT) && !aw_got);
  assign wready  = ((state == IDLE) && !arvalid) || ((state == WR_COLLECT) && !w_got);

  assign ar_hs  = arvalid && arready;
  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign wr_go  = (state == WR_COLLECT) && aw_got && w_got;
  assign mem_we = wr_go && wr_ok && !rst;

  generate
    if (MODE == 0) begin : g_sram
      logic [31:0] mem [DEPTH];

      always_ff @(posedge clk) begin
        if (mem_we) begin
          for (int i = 0; i < 4; i++) begin
            if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
          end
        end
      end

      assign rd_word = mem[rd_idx];
    end else begin : g_uart
      // Word 1 is the line status register: THRE permanently set.
      assign rd_word = (rd_idx == AW'(1)) ? 32'h0000_2000 : 32'h0000_0000;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rvalid   <= 1'b0;
      bvalid   <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      rdata    <= 32'h0;
      rresp    <= 1'b0;
      bresp    <= 1'b0;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      wr_err   <= 1'b0;
      wr_thr   <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      if (aw_hs) begin
        wr_addr <= awaddr;
        aw_got  <= 1'b1;
      end
      if (w_hs) begin
        wr_data <= wdata;
        wr_strb <= wstrb[3:0];
        w_got   <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (ar_hs) begin
            rd_addr <= araddr;
            cnt     <= CNT_LOAD;
            state   <= RD_WAIT;
          end else if (aw_hs || w_hs) begin
            state <= WR_COLLECT;
          end
        end
        RD_WAIT: begin
          if (cnt == '0) begin
            rvalid <= 1'b1;
            rresp  <= !rd_ok;
            rdata  <= rd_ok ? rd_word : 32'h0;
            state  <= RD_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RD_RESP: begin
          if (rready) begin
            rvalid <= 1'b0;
            state  <= IDLE;
          end
        end
        WR_COLLECT: begin
          // The memory write itself happens on this edge via mem_we.
          if (wr_go) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            wr_err <= !wr_ok;
            wr_thr <= (MODE == 1) && wr_ok && (wr_idx == '0) && wr_strb[0];
            cnt    <= CNT_LOAD;
            state  <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (cnt == '0) begin
            bvalid   <= 1'b1;
            bresp    <= wr_err;
            tx_valid <= wr_thr;
            if (wr_thr) tx_data <= wr_data[7:0];
            state    <= WR_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WR_RESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{wstrb[31:4], rd_off[1:0], wr_off[1:0], wr_data, wr_strb, mem_we};

endmodule

// File: tb/tb_axil_mem_uart_slave.sv
// Bench for the SRAM (index 0) and UART (index 1) builds of axil_mem_uart_slave; responses checked by a scoreboard monitor.
module tb_axil_mem_uart_slave;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0][31:0] araddr, rdata, awaddr, wdata, wstrb;
  logic [1:0]       arvalid, arready, rready, rresp, rvalid;
  logic [1:0]       awvalid, awready, wvalid, wready, bready, bresp, bvalid, tx_valid;
  logic [1:0][7:0]  tx_data;

  typedef struct packed {logic [31:0] d; logic e;} rexp_t;
  rexp_t rq[$];
  logic  bq[$];
  rexp_t mon_r;
  logic  mon_b;

  int checks = 0;
  int failures = 0;
  int tx_cnt[2];
  logic [7:0] tx_last;
  logic       tx_with_b;
  int lat, lat2;

  axil_mem_uart_slave #(.MODE(0), .BASE(32'h8000_0000), .SIZE_LOG2(14), .LATENCY(1)) u_sram (
    .clk(clk), .rst(rst),
    .araddr(araddr[0]), .arvalid(arvalid[0]), .arready(arready[0]),
    .rready(rready[0]), .rdata(rdata[0]), .rresp(rresp[0]), .rvalid(rvalid[0]),
    .awaddr(awaddr[0]), .awvalid(awvalid[0]), .awready(awready[0]),
    .wdata(wdata[0]), .wstrb(wstrb[0]), .wvalid(wvalid[0]), .wready(wready[0]),
    .bready(bready[0]), .bresp(bresp[0]), .bvalid(bvalid[0]),
    .tx_valid(tx_valid[0]), .tx_data(tx_data[0])
  );

  axil_mem_uart_slave #(.MODE(1), .BASE(32'h1000_0000), .SIZE_LOG2(12), .LATENCY(1)) u_uart (
    .clk(clk), .rst(rst),
    .araddr(araddr[1]), .arvalid(arvalid[1]), .arready(arready[1]),
    .rready(rready[1]), .rdata(rdata[1]), .rresp(rresp[1]), .rvalid(rvalid[1]),
    .awaddr(awaddr[1]), .awvalid(awvalid[1]), .awready(awready[1]),
    .wdata(wdata[1]), .wstrb(wstrb[1]), .wvalid(wvalid[1]), .wready(wready[1]),
    .bready(bready[1]), .bresp(bresp[1]), .bvalid(bvalid[1]),
    .tx_valid(tx_valid[1]), .tx_data(tx_data[1])
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: pops an expectation on every completed response handshake.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst && rvalid[k] && rready[k]) begin
        if (rq.size() == 0) check("unexpected_rvalid", 32'd1, 32'd0);
        else begin
          mon_r = rq.pop_front();
          check("rdata", rdata[k], mon_r.d);
          check("rresp", {31'd0, rresp[k]}, {31'd0, mon_r.e});
        end
      end
      if (!rst && bvalid[k] && bready[k]) begin
        if (bq.size() == 0) check("unexpected_bvalid", 32'd1, 32'd0);
        else begin
          mon_b = bq.pop_front();
          check("bresp", {31'd0, bresp[k]}, {31'd0, mon_b});
        end
      end
      if (tx_valid[k]) begin
        tx_cnt[k]++;
        tx_last   = tx_data[k];
        tx_with_b = bvalid[k];
        $display("uart tx char '%c'", tx_data[k]);
      end
    end
  end

  task automatic do_read(input int k, input logic [31:0] a, input logic [31:0] exp_d,
                         input logic exp_e, input int hold);
    int c;
    rexp_t r;
    r.d = exp_d;
    r.e = exp_e;
    rq.push_back(r);
    @(posedge clk); #1;
    araddr[k] = a; arvalid[k] = 1'b1; rready[k] = (hold == 0);
    c = 0;
    do begin @(negedge clk); c++; end while (!arready[k] && c < 100);
    if (!arready[k]) check("ar_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    arvalid[k] = 1'b0;
    c = 0;
    do begin @(negedge clk); c++; end while (!rvalid[k] && c < 100);
    if (!rvalid[k]) check("r_timeout", 32'd1, 32'd0);
    for (int i = 0; i < hold; i++) begin
      check("hold_rvalid", {31'd0, rvalid[k]}, 32'd1);
      check("hold_rdata", rdata[k], exp_d);
      check("hold_arready", {31'd0, arready[k]}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    if (hold > 0) begin
      rready[k] = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      rready[k] = 1'b0;
      @(negedge clk);
      check("rvalid_after_accept", {31'd0, rvalid[k]}, 32'd0);
    end else begin
      rready[k] = 1'b0;
    end
  endtask

  task automatic do_write(input int k, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int gap, input logic exp_e, output int l);
    bit aw_done, w_done, aw_f, w_f;
    int c;
    bq.push_back(exp_e);
    @(posedge clk); #1;
    awaddr[k] = a; wdata[k] = d; wstrb[k] = {28'hABCDEF1, s};
    awvalid[k] = 1'b1; wvalid[k] = (gap == 0); bready[k] = 1'b1;
    aw_done = 0; w_done = 0; c = 0;
    while (!(aw_done && w_done) && c < 100) begin
      @(negedge clk);
      aw_f = awvalid[k] && awready[k];
      w_f  = wvalid[k] && wready[k];
      @(posedge clk); #1;
      c++;
      if (aw_f) begin awvalid[k] = 1'b0; aw_done = 1; end
      if (w_f)  begin wvalid[k]  = 1'b0; w_done  = 1; end
      if (c == gap && !w_done) wvalid[k] = 1'b1;
    end
    if (!(aw_done && w_done)) check("aw_w_timeout", 32'd1, 32'd0);
    l = -1;
    do begin @(negedge clk); l++; end while (!bvalid[k] && l < 100);
    if (!bvalid[k]) check("b_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    bready[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    araddr = '0; awaddr = '0; wdata = '0; wstrb = '0;
    arvalid = '0; rready = '0; awvalid = '0; wvalid = '0; bready = '0;
    tx_cnt[0] = 0; tx_cnt[1] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_rvalid",   {31'd0, rvalid[k]},   32'd0);
      check("rst_bvalid",   {31'd0, bvalid[k]},   32'd0);
      check("rst_tx_valid", {31'd0, tx_valid[k]}, 32'd0);
      check("rst_arready",  {31'd0, arready[k]},  32'd1);
      check("rst_awready",  {31'd0, awready[k]},  32'd1);
      check("rst_rdata",    rdata[k],             32'd0);
    end

    // SRAM: full write, latency, read back, byte strobes
    do_write(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, lat);
    check("b_latency", lat, 32'd2);
    do_read(0, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0, 0);
    do_write(0, 32'h8000_0010, 32'h1122_3344, 4'h5, 0, 1'b0, lat);
    do_read(0, 32'h8000_0010, 32'hDE22_BE44, 1'b0, 0);

    // Address three cycles ahead of data
    do_write(0, 32'h8000_0014, 32'h0BAD_F00D, 4'hF, 3, 1'b0, lat);
    do_read(0, 32'h8000_0014, 32'h0BAD_F00D, 1'b0, 0);

    // Simultaneous read and write: read must see the old value
    do_write(0, 32'h8000_0020, 32'hAAAA_0001, 4'hF, 0, 1'b0, lat);
    fork
      do_read(0, 32'h8000_0020, 32'hAAAA_0001, 1'b0, 0);
      do_write(0, 32'h8000_0020, 32'hBBBB_0002, 4'hF, 0, 1'b0, lat2);
    join
    do_read(0, 32'h8000_0020, 32'hBBBB_0002, 1'b0, 0);

    // Read backpressure
    do_read(0, 32'h8000_0010, 32'hDE22_BE44, 1'b0, 5);

    // Error responses leave memory untouched
    do_write(0, 32'h8000_0000, 32'h1234_5678, 4'hF, 0, 1'b0, lat);
    do_read(0, 32'h9000_0000, 32'h0, 1'b1, 0);
    do_write(0, 32'h0000_0000, 32'hFFFF_FFFF, 4'hF, 0, 1'b1, lat);
    do_read(0, 32'h8000_0000, 32'h1234_5678, 1'b0, 0);

    // Region edges
    do_write(0, 32'h8000_3FFC, 32'hCAFE_F00D, 4'hF, 0, 1'b0, lat);
    do_read(0, 32'h8000_3FFF, 32'hCAFE_F00D, 1'b0, 0);
    do_read(0, 32'h8000_4000, 32'h0, 1'b1, 0);
    do_write(0, 32'h8000_4000, 32'h5555_5555, 4'hF, 0, 1'b1, lat);
    do_read(0, 32'h7FFF_FFFC, 32'h0, 1'b1, 0);
    check("sram_tx_count", tx_cnt[0], 32'd0);

    // UART
    do_write(1, 32'h1000_0000, 32'h0000_0041, 4'h1, 0, 1'b0, lat);
    check("uart_tx_count", tx_cnt[1], 32'd1);
    check("uart_tx_data", {24'd0, tx_last}, 32'h41);
    check("uart_tx_with_bvalid", {31'd0, tx_with_b}, 32'd1);
    do_write(1, 32'h1000_0000, 32'h0000_0042, 4'h2, 0, 1'b0, lat);
    do_write(1, 32'h1000_0008, 32'h0000_0043, 4'hF, 0, 1'b0, lat);
    check("uart_tx_count_nochange", tx_cnt[1], 32'd1);
    do_read(1, 32'h1000_0004, 32'h0000_2000, 1'b0, 0);
    do_read(1, 32'h1000_0008, 32'h0, 1'b0, 0);
    do_read(1, 32'h1000_1000, 32'h0, 1'b1, 0);

    // Reset while in RD_WAIT aborts the read
    @(posedge clk); #1;
    araddr[1] = 32'h1000_0004; arvalid[1] = 1'b1; rready[1] = 1'b1;
    @(negedge clk);
    check("abort_arready_idle", {31'd0, arready[1]}, 32'd1);
    @(posedge clk); #1;
    arvalid[1] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_rvalid", {31'd0, rvalid[1]}, 32'd0);
    check("abort_arready", {31'd0, arready[1]}, 32'd1);
    repeat (3) @(negedge clk);
    check("abort_rvalid_later", {31'd0, rvalid[1]}, 32'd0);
    rready[1] = 1'b0;

    repeat (2) @(negedge clk);
    check("rq_drained", rq.size(), 32'd0);
    check("bq_drained", bq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
